muldiv_unit: RTL and testbench

Iterative, parametrised multiply/divide unit with internal HI/LO registers for the pipelined MIPS datapath. It replaces the single-cycle ALU multiply path and the stand-alone HI/LO registers. It adds:
- unsigned and signed divide;
- multiply-accumulate and multiply-subtract;
- direct HI/LO writes;
- a Busy/Done handshake, which the hazard logic uses to stall `mfhi`/`mflo` in ID.

It sits in EX, alongside the ALU.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_iter.sv | 59 +++++
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings, FSM states and helpers for the multiply/divide unit
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MSUB  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } state_e;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

  function automatic logic op_is_div(input op_e op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - radix-2 shift-add multiply / restoring divide engine on magnitudes
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] acc,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;

  // Both modes start from {0, a}: upper half is partial product / remainder.
  always_comb begin
    acc_d     = acc_q;
    b_d       = b_q;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, b_q};
    if (load) begin
      acc_d = {{WIDTH{1'b0}}, a_mag};
      b_d   = b_mag;
    end else if (step) begin
      if (is_div) begin
        if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else                  acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
    end
  end

  assign acc       = acc_q;
  assign quotient  = acc_q[WIDTH-1:0];
  assign remainder = acc_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with HI/LO, accumulate and busy/done handshake
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Abort,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic             sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  op_e                op_in;
  logic               in_signed, iter_load, iter_step;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] acc, prod_fix, hilo;

  assign op_in     = op_e'(Op);
  assign in_signed = op_is_signed(op_in);
  assign a_mag     = (in_signed && A[WIDTH-1]) ? -A : A;
  assign b_mag     = (in_signed && B[WIDTH-1]) ? -B : B;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (Clk),
    .rst      (Rst),
    .load     (iter_load),
    .step     (iter_step),
    .is_div   (op_is_div(op_q)),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .acc      (acc),
    .quotient (quo),
    .remainder(rem)
  );

  // Sign bits are latched as 0 for unsigned ops, so these only fire for signed ones.
  assign prod_fix = (sa_q ^ sb_q) ? -acc : acc;
  assign quo_fix  = (sa_q ^ sb_q) ? -quo : quo;
  assign rem_fix  = sa_q ? -rem : rem;
  assign hilo     = {hi_q, lo_q};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    bz_d      = bz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    iter_load = 1'b0;
    iter_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start && !Abort) begin
          if (op_in == OP_MTHI) begin
            hi_d   = A;
            done_d = 1'b1;
          end else if (op_in == OP_MTLO) begin
            lo_d   = A;
            done_d = 1'b1;
          end else begin
            iter_load = 1'b1;
            op_d      = op_in;
            a_d       = A;
            sa_d      = in_signed && A[WIDTH-1];
            sb_d      = in_signed && B[WIDTH-1];
            bz_d      = (B == '0);
            cnt_d     = CNT_INIT;
            state_d   = ST_CALC;
            busy_d    = 1'b1;
          end
        end
      end
      ST_CALC: begin
        if (Abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          iter_step = 1'b1;
          if (cnt_q == '0) state_d = ST_FIXUP;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_FIXUP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (!Abort) begin
          done_d = 1'b1;
          case (op_q)
            OP_MULT, OP_MULTU: {hi_d, lo_d} = prod_fix;
            OP_MADD:           {hi_d, lo_d} = hilo + prod_fix;
            OP_MSUB:           {hi_d, lo_d} = hilo - prod_fix;
            OP_DIV, OP_DIVU: begin
              if (bz_q) begin
                lo_d  = '1;
                hi_d  = a_q;
                dbz_d = 1'b1;
              end else begin
                lo_d = quo_fix;
                hi_d = rem_fix;
              end
            end
            default: ;
          endcase
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= '0;
      a_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed scoreboard bench for muldiv_unit at WIDTH = 32
module tb_muldiv_unit;

  logic        Clk, Rst, Start, Abort;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done, DivByZero;
  logic [31:0] Hi, Lo;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat;
  int          seen;
  logic [63:0] model_hl;
  logic [64:0] sb[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .Op       (Op),
    .A        (A),
    .B        (B),
    .Abort    (Abort),
    .Busy     (Busy),
    .Done     (Done),
    .DivByZero(DivByZero),
    .Hi       (Hi),
    .Lo       (Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {dbz, hi, lo} from plain SV arithmetic
  function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    longint      sa, sb;
    int          ia, ib;
    logic [63:0] sp, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    sp = 64'(sa * sb);
    up = {32'd0, a} * {32'd0, b};
    case (op)
      3'd0: model = {1'b0, sp};
      3'd1: model = {1'b0, up};
      3'd2: begin
        if (b == 32'd0)                                model = {1'b1, a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {1'b0, 32'd0, 32'h8000_0000};
        else                                           model = {1'b0, 32'(ia % ib), 32'(ia / ib)};
      end
      3'd3: begin
        if (b == 32'd0) model = {1'b1, a, 32'hFFFF_FFFF};
        else            model = {1'b0, a % b, a / b};
      end
      3'd4: model = {1'b0, hl + sp};
      3'd5: model = {1'b0, hl - sp};
      3'd6: model = {1'b0, a, hl[31:0]};
      default: model = {1'b0, hl[63:32], a};
    endcase
  endfunction

  task automatic push_expect(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [64:0] r;
    r = model(op, a, b, model_hl);
    model_hl = r[63:0];
    sb.push_back(r);
  endtask

  task automatic pop_compare(input string tag);
    logic [64:0] e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_hi"}, {32'd0, Hi}, {32'd0, e[63:32]});
      check({tag, "_lo"}, {32'd0, Lo}, {32'd0, e[31:0]});
      check({tag, "_dbz"}, {63'd0, DivByZero}, {63'd0, e[64]});
      check({tag, "_busy"}, {63'd0, Busy}, 64'd0);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      n++;
      if (Done) break;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    push_expect(op, a, b);
    Op = op; A = a; B = b; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    if (op >= 3'd6) begin
      check({tag, "_done"}, {63'd0, Done}, 64'd1);
    end else begin
      check({tag, "_busy_on"}, {63'd0, Busy}, 64'd1);
      wait_done(n);
      check({tag, "_latency"}, 64'(n), 64'd33);
    end
    pop_compare(tag);
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; Abort = 1'b0; Op = 3'd0; A = '0; B = '0;
    model_hl = '0;
    #12;
    check("rst_hi", {32'd0, Hi}, 64'd0);
    check("rst_lo", {32'd0, Lo}, 64'd0);
    check("rst_busy", {63'd0, Busy}, 64'd0);
    check("rst_done", {63'd0, Done}, 64'd0);
    check("rst_dbz", {63'd0, DivByZero}, 64'd0);
    @(negedge Clk);
    Rst = 1'b0;

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_neg7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_by0", 3'd3, 32'h0000_1234, 32'd0);
    run_op("div_by0_neg", 3'd2, 32'hFFFF_FFF0, 32'd0);
    run_op("mthi", 3'd6, 32'd0, 32'd0);
    run_op("mtlo", 3'd7, 32'd10, 32'd0);
    run_op("madd", 3'd4, 32'd3, 32'hFFFF_FFFE);
    run_op("msub", 3'd5, 32'd2, 32'd3);
    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5);

    // Abort in IDLE drops the request
    Op = 3'd6; A = 32'hDEAD_BEEF; Start = 1'b1; Abort = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; Abort = 1'b0;
    check("idle_abort_done", {63'd0, Done}, 64'd0);
    check("idle_abort_hi", {32'd0, Hi}, {32'd0, model_hl[63:32]});

    // Abort during CALC
    Op = 3'd0; A = 32'd5; B = 32'd7; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (10) begin @(posedge Clk); #1; end
    check("calc_hold_hi", {32'd0, Hi}, {32'd0, model_hl[63:32]});
    Abort = 1'b1;
    @(posedge Clk); #1;
    Abort = 1'b0;
    check("abort_busy", {63'd0, Busy}, 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    check("abort_hilo", {Hi, Lo}, model_hl);

    // Asynchronous reset mid-CALC
    Op = 3'd0; A = 32'd5; B = 32'd7; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (5) begin @(posedge Clk); #1; end
    #2 Rst = 1'b1;
    #1;
    check("async_rst_hi", {32'd0, Hi}, 64'd0);
    check("async_rst_lo", {32'd0, Lo}, 64'd0);
    check("async_rst_busy", {63'd0, Busy}, 64'd0);
    model_hl = '0;
    @(negedge Clk);
    Rst = 1'b0;

    // Start held high through a whole DIVU, then re-accepted in the Done cycle
    push_expect(3'd3, 32'd100, 32'd7);
    Op = 3'd3; A = 32'd100; B = 32'd7; Start = 1'b1;
    @(posedge Clk); #1;
    A = 32'd1000;
    wait_done(lat);
    check("hold_start_latency", 64'(lat), 64'd33);
    pop_compare("hold_start_first");
    push_expect(3'd3, 32'd1000, 32'd7);
    @(posedge Clk); #1;
    Start = 1'b0;
    check("b2b_busy", {63'd0, Busy}, 64'd1);
    wait_done(lat);
    check("b2b_latency", 64'(lat), 64'd33);
    pop_compare("b2b_second");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
